seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier.sv | 117 +++++++++++
 tb/tb_seq_multiplier.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per cycle over BITS cycles,
// unsigned or two's-complement (sign-magnitude internally), with start/finished handshake.
module seq_multiplier #(
  parameter int BITS = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_signed,
  input  logic [BITS-1:0]     i_multiplier,
  input  logic [BITS-1:0]     i_multiplicand,
  output logic [2*BITS-1:0]   o_product,
  output logic                o_busy,
  output logic                o_finished
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [BITS-1:0]     mag_a_reg;
  logic [BITS-1:0]     mag_b_reg;
  logic [2*BITS:0]     acc_reg;
  logic [CW-1:0]       count_reg;
  logic                sign_reg;
  logic [2*BITS-1:0]   product_reg;
  logic                busy_reg;
  logic                finished_reg;

  logic [BITS-1:0]     a_mag_next;
  logic [BITS-1:0]     b_mag_next;
  logic                sign_next;
  logic [BITS:0]       addend;
  logic [2*BITS:0]     acc_added;
  logic [2*BITS:0]     acc_next;
  logic [2*BITS-1:0]   acc_low;
  logic [2*BITS-1:0]   product_next;

  // Magnitudes are BITS wide unsigned, so -2^(BITS-1) maps to 2^(BITS-1) without overflow.
  always_comb begin
    a_mag_next = i_multiplier;
    b_mag_next = i_multiplicand;
    sign_next  = 1'b0;
    if (i_signed) begin
      if (i_multiplier[BITS-1])
        a_mag_next = ~i_multiplier + BITS'(1);
      if (i_multiplicand[BITS-1])
        b_mag_next = ~i_multiplicand + BITS'(1);
      sign_next = i_multiplier[BITS-1] ^ i_multiplicand[BITS-1];
    end
  end

  // The add is BITS+1 wide so its carry lands in acc bit 2*BITS before the shift.
  always_comb begin
    addend       = mag_a_reg[0] ? {1'b0, mag_b_reg} : '0;
    acc_added    = {acc_reg[2*BITS:BITS] + addend, acc_reg[BITS-1:0]};
    acc_next     = acc_added >> 1;
    acc_low      = acc_reg[2*BITS-1:0];
    product_next = (sign_reg && (acc_low != '0)) ? ('0 - acc_low) : acc_low;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg    <= S_IDLE;
      mag_a_reg    <= '0;
      mag_b_reg    <= '0;
      acc_reg      <= '0;
      count_reg    <= '0;
      sign_reg     <= 1'b0;
      product_reg  <= '0;
      busy_reg     <= 1'b0;
      finished_reg <= 1'b0;
    end else begin
      finished_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (i_start) begin
            mag_a_reg <= a_mag_next;
            mag_b_reg <= b_mag_next;
            sign_reg  <= sign_next;
            acc_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          acc_reg   <= acc_next;
          mag_a_reg <= mag_a_reg >> 1;
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(BITS - 1))
            state_reg <= S_DONE;
        end
        S_DONE: begin
          product_reg  <= product_next;
          finished_reg <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_product  = product_reg;
  assign o_busy     = busy_reg;
  assign o_finished = finished_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at BITS=8, plus width-scaled cases at BITS=2 and BITS=16.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        busy8, fin8;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;
  logic        busy2, fin2;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        busy16, fin16;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier #(.BITS(8)) dut8 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_signed(sgn),
    .i_multiplier(a8), .i_multiplicand(b8),
    .o_product(p8), .o_busy(busy8), .o_finished(fin8)
  );

  seq_multiplier #(.BITS(2)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_signed(sgn),
    .i_multiplier(a2), .i_multiplicand(b2),
    .o_product(p2), .o_busy(busy2), .o_finished(fin2)
  );

  seq_multiplier #(.BITS(16)) dut16 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_signed(sgn),
    .i_multiplier(a16), .i_multiplicand(b16),
    .o_product(p16), .o_busy(busy16), .o_finished(fin16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Counts negedges from start_cnt; lat is the index at which fin8 is first seen (0 = timeout).
  task automatic wait_done8(input int start_cnt, output int lat);
    lat = 0;
    for (int i = start_cnt + 1; i <= start_cnt + 40 && lat == 0; i++) begin
      @(negedge clk);
      if (fin8) lat = i;
    end
  endtask

  task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int lat;
    @(negedge clk);
    sgn = s; a8 = a; b8 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, " busy"}, 64'(busy8), 64'd1);
    wait_done8(0, lat);
    check_eq({tag, " latency"}, 64'(lat), 64'd9);
    check_eq({tag, " product"}, 64'(p8), 64'(exp));
    check_eq({tag, " busy at finish"}, 64'(busy8), 64'd0);
    @(negedge clk);
    check_eq({tag, " finished pulse width"}, 64'(fin8), 64'd0);
  endtask

  task automatic run_scaled(input string tag, input logic s,
                            input logic [1:0] a_2, input logic [1:0] b_2, input logic [3:0] exp2,
                            input logic [15:0] a_16, input logic [15:0] b_16, input logic [31:0] exp16);
    int lat2, lat16;
    logic [3:0]  cap2;
    logic [31:0] cap16;
    lat2 = 0; lat16 = 0; cap2 = '0; cap16 = '0;
    repeat (20) @(negedge clk);
    sgn = s; a2 = a_2; b2 = b_2; a16 = a_16; b16 = b_16; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (fin2 && lat2 == 0) begin lat2 = i; cap2 = p2; end
      if (fin16 && lat16 == 0) begin lat16 = i; cap16 = p16; end
    end
    check_eq({tag, " w2 latency"}, 64'(lat2), 64'd3);
    check_eq({tag, " w2 product"}, 64'(cap2), 64'(exp2));
    check_eq({tag, " w16 latency"}, 64'(lat16), 64'd17);
    check_eq({tag, " w16 product"}, 64'(cap16), 64'(exp16));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, sp, extra, hold_bad;
    rst = 1'b1; start = 1'b1; sgn = 1'b0;
    a8 = 8'd1; b8 = 8'd1; a2 = 2'd1; b2 = 2'd1; a16 = 16'd1; b16 = 16'd1;

    // Reset for two cycles with start held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset product", 64'(p8), 64'd0);
    check_eq("reset busy", 64'(busy8), 64'd0);
    check_eq("reset finished", 64'(fin8), 64'd0);
    check_eq("reset w16 busy", 64'(busy16), 64'd0);
    check_eq("reset w2 product", 64'(p2), 64'd0);
    rst = 1'b0; start = 1'b0;

    run8("u 13x11",    1'b0, 8'd13,  8'd11,  16'h008F);
    run8("u 255x255",  1'b0, 8'hFF,  8'hFF,  16'hFE01);
    run8("s -3x5",     1'b1, 8'hFD,  8'h05,  16'hFFF1);
    run8("s -128x-128",1'b1, 8'h80,  8'h80,  16'h4000);
    run8("s -128x127", 1'b1, 8'h80,  8'h7F,  16'hC080);
    run8("s 0x-7",     1'b1, 8'h00,  8'hF9,  16'h0000);

    // Busy rejection and operand stability
    @(negedge clk);
    sgn = 1'b0; a8 = 8'd6; b8 = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; a8 = 8'd2; b8 = 8'd2;
    @(negedge clk);
    start = 1'b0; a8 = 8'hFF; b8 = 8'h80;
    wait_done8(2, lat);
    check_eq("reject latency", 64'(lat), 64'd9);
    check_eq("reject product", 64'(p8), 64'h002A);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fin8) extra++;
    end
    check_eq("reject no second finish", 64'(extra), 64'd0);

    // Back-to-back with start held high
    @(negedge clk);
    sgn = 1'b0; a8 = 8'd3; b8 = 8'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd6;
    wait_done8(0, lat);
    check_eq("b2b first latency", 64'(lat), 64'd9);
    check_eq("b2b first product", 64'(p8), 64'h000C);
    sp = 0; hold_bad = 0;
    for (int i = 1; i <= 30 && sp == 0; i++) begin
      @(negedge clk);
      if (fin8) begin
        sp = i;
        start = 1'b0;
      end else if (p8 !== 16'h000C) begin
        hold_bad++;
      end
    end
    start = 1'b0;
    check_eq("b2b spacing", 64'(sp), 64'd10);
    check_eq("b2b second product", 64'(p8), 64'h001E);
    check_eq("b2b product held", 64'(hold_bad), 64'd0);
    repeat (12) @(negedge clk);
    check_eq("b2b idle after", 64'(busy8), 64'd0);

    // Reset mid-run
    @(negedge clk);
    sgn = 1'b0; a8 = 8'd9; b8 = 8'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (fin8) extra++;
      if (i == 3) rst = 1'b1;
      if (i == 5) rst = 1'b0;
    end
    check_eq("midreset no finish", 64'(extra), 64'd0);
    check_eq("midreset product", 64'(p8), 64'd0);
    check_eq("midreset busy", 64'(busy8), 64'd0);
    run8("after reset 2x3", 1'b0, 8'd2, 8'd3, 16'h0006);

    // Width-scaled extremes
    run_scaled("umax", 1'b0, 2'b11, 2'b11, 4'h9, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_scaled("smin", 1'b1, 2'b10, 2'b10, 4'h4, 16'h8000, 16'h8000, 32'h40000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
